// File: rtl/pixel_packet_parser_pkg.sv
// Shared link definitions for the pixel-encoded packet link: framing constants,
// parser state encoding, error codes and the header word builder.
package pixel_packet_parser_pkg;

   localparam logic [47:0] SOF_WORD = 48'h01000000FFEA;
   localparam logic [7:0]  EOF_B0   = 8'hAA;
   localparam logic [7:0]  EOF_B1   = 8'hDD;
   localparam int          LANES    = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2,
      ST_EOF2 = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_HDR   = 2'd1,
      ERR_EOF   = 2'd2,
      ERR_TRUNC = 2'd3
   } err_code_e;

   // Header carries the length with its low byte in byte4 and high byte in byte1.
   function automatic logic [47:0] hdr_word(input logic [7:0] phl_id,
                                            input logic [31:0] dlen,
                                            input logic [7:0] dtype);
      return {phl_id, dlen[7:0], dlen[15:8], dlen[23:16], dlen[31:24], dtype};
   endfunction

endpackage

// File: rtl/pixel_byte_lane_unpack.sv
// Per-lane classification of one 48-bit pixel word given the lane where the
// EOF marker is due (6 = no EOF in this word).
module pixel_byte_lane_unpack
   import pixel_packet_parser_pkg::*;
(
   input  logic [47:0] word,
   input  logic [2:0]  eof_lane,
   output logic [5:0]  pay_en,
   output logic        aa_hit,
   output logic        dd_hit,
   output logic        dd_next
);

   // Lanes below the EOF lane carry payload; DD follows AA unless AA sits in byte5.
   always_comb begin
      pay_en  = 6'b000000;
      aa_hit  = 1'b0;
      dd_hit  = 1'b0;
      dd_next = (eof_lane == 3'd5);
      for (int i = 0; i < LANES; i++) begin
         pay_en[i] = (3'(i) < eof_lane);
         aa_hit    = aa_hit | ((eof_lane == 3'(i)) && (word[8*i +: 8] == EOF_B0));
      end
      for (int i = 0; i < LANES - 1; i++) begin
         dd_hit = dd_hit | ((eof_lane == 3'(i)) && (word[8*i+8 +: 8] == EOF_B1));
      end
   end

endmodule

// File: rtl/pixel_packet_parser.sv
// Receive-side deframer: finds SOF, checks repeated headers, gathers DLEN payload
// bytes into a shadow register and publishes them only after a good EOF.
module pixel_packet_parser
   import pixel_packet_parser_pkg::*;
#(
   parameter int unsigned DLEN       = 32'd43,
   parameter int unsigned HDR_REPEAT = 32'd2,
   parameter logic [7:0]  PHL_ID     = 8'h00,
   parameter logic [7:0]  DTYPE_EXP  = 8'h01
)
(
   input  logic                rx_pixel_clk,
   input  logic                rst_n,
   input  logic                frame_start,
   input  logic                pixel_valid,
   input  logic [47:0]         pixel_data,
   output logic [DLEN*8-1:0]   payload,
   output logic                payload_valid,
   output logic                busy,
   output logic                err,
   output logic [1:0]          err_code
);

   localparam int              DLEN_I   = int'(DLEN);
   localparam int              BW       = $clog2(DLEN + 1);
   localparam int              HW       = (HDR_REPEAT > 1) ? $clog2(HDR_REPEAT) : 1;
   localparam logic [BW-1:0]   DLEN_B   = BW'(DLEN);
   localparam logic [HW-1:0]   HDR_LAST = HW'(HDR_REPEAT - 1);
   localparam logic [47:0]     HDR_WORD = hdr_word(PHL_ID, 32'(DLEN), DTYPE_EXP);

   state_e              state_r, state_nxt_s;
   logic [HW-1:0]       hcnt_r, hcnt_nxt_s;
   logic [BW-1:0]       bcnt_r, bcnt_nxt_s;
   logic [BW-1:0]       rem_s;
   logic [2:0]          eof_lane_s;
   logic [DLEN*8-1:0]   shadow_r, shadow_nxt_s, payload_r;
   logic                payload_valid_r, payload_valid_nxt_s;
   logic                busy_r, busy_nxt_s;
   logic                err_r, err_nxt_s;
   logic [1:0]          err_code_r, err_code_nxt_s;
   logic                load_s, pay_write_s, abort_s;
   logic [5:0]          pay_en_s;
   logic                aa_hit_s, dd_hit_s, dd_next_s;

   assign rem_s       = DLEN_B - bcnt_r;
   assign eof_lane_s  = (int'(rem_s) >= LANES) ? 3'd6 : 3'(rem_s);
   assign abort_s     = frame_start && busy_r;
   assign pay_write_s = pixel_valid && (state_r == ST_PAY) && !abort_s;

   pixel_byte_lane_unpack u_unpack (
      .word     (pixel_data),
      .eof_lane (eof_lane_s),
      .pay_en   (pay_en_s),
      .aa_hit   (aa_hit_s),
      .dd_hit   (dd_hit_s),
      .dd_next  (dd_next_s)
   );

   // Shadow update: payload lane i lands in slot bcnt+i.
   always_comb begin
      shadow_nxt_s = shadow_r;
      for (int s = 0; s < DLEN_I; s++) begin
         for (int i = 0; i < LANES; i++) begin
            shadow_nxt_s[8*s +: 8] = (pay_write_s && pay_en_s[i] && (int'(bcnt_r) + i == s))
                                     ? pixel_data[8*i +: 8] : shadow_nxt_s[8*s +: 8];
         end
      end
   end

   // Next-state and output decode; frame_start mid-packet overrides any pixel word.
   always_comb begin
      state_nxt_s         = state_r;
      hcnt_nxt_s          = hcnt_r;
      bcnt_nxt_s          = bcnt_r;
      busy_nxt_s          = busy_r;
      err_nxt_s           = 1'b0;
      err_code_nxt_s      = err_code_r;
      payload_valid_nxt_s = 1'b0;
      load_s              = 1'b0;
      if (abort_s) begin
         state_nxt_s    = ST_IDLE;
         busy_nxt_s     = 1'b0;
         err_nxt_s      = 1'b1;
         err_code_nxt_s = ERR_TRUNC;
      end else if (pixel_valid) begin
         case (state_r)
            ST_IDLE: begin
               if (pixel_data == SOF_WORD) begin
                  state_nxt_s = ST_HDR;
                  busy_nxt_s  = 1'b1;
                  hcnt_nxt_s  = '0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_HDR: begin
               if (pixel_data != HDR_WORD) begin
                  state_nxt_s    = ST_IDLE;
                  busy_nxt_s     = 1'b0;
                  err_nxt_s      = 1'b1;
                  err_code_nxt_s = ERR_HDR;
               end else if (hcnt_r == HDR_LAST) begin
                  state_nxt_s = ST_PAY;
                  bcnt_nxt_s  = '0;
               end else begin
                  hcnt_nxt_s = hcnt_r + HW'(1);
               end
            end
            ST_PAY: begin
               if (eof_lane_s == 3'd6) begin
                  bcnt_nxt_s = bcnt_r + BW'(LANES);
               end else if (!aa_hit_s) begin
                  state_nxt_s    = ST_IDLE;
                  busy_nxt_s     = 1'b0;
                  err_nxt_s      = 1'b1;
                  err_code_nxt_s = ERR_EOF;
               end else if (dd_next_s) begin
                  state_nxt_s = ST_EOF2;
                  bcnt_nxt_s  = DLEN_B;
               end else if (dd_hit_s) begin
                  state_nxt_s         = ST_IDLE;
                  busy_nxt_s          = 1'b0;
                  payload_valid_nxt_s = 1'b1;
                  load_s              = 1'b1;
               end else begin
                  state_nxt_s    = ST_IDLE;
                  busy_nxt_s     = 1'b0;
                  err_nxt_s      = 1'b1;
                  err_code_nxt_s = ERR_EOF;
               end
            end
            ST_EOF2: begin
               state_nxt_s = ST_IDLE;
               busy_nxt_s  = 1'b0;
               if (pixel_data[7:0] == EOF_B1) begin
                  payload_valid_nxt_s = 1'b1;
                  load_s              = 1'b1;
               end else begin
                  err_nxt_s      = 1'b1;
                  err_code_nxt_s = ERR_EOF;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               busy_nxt_s  = 1'b0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, counters, shadow and published outputs.
   always_ff @(posedge rx_pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= ST_IDLE;
         hcnt_r          <= '0;
         bcnt_r          <= '0;
         shadow_r        <= '0;
         payload_r       <= '0;
         payload_valid_r <= 1'b0;
         busy_r          <= 1'b0;
         err_r           <= 1'b0;
         err_code_r      <= 2'd0;
      end else begin
         state_r         <= state_nxt_s;
         hcnt_r          <= hcnt_nxt_s;
         bcnt_r          <= bcnt_nxt_s;
         shadow_r        <= shadow_nxt_s;
         payload_valid_r <= payload_valid_nxt_s;
         busy_r          <= busy_nxt_s;
         err_r           <= err_nxt_s;
         err_code_r      <= err_code_nxt_s;
         if (load_s) begin
            payload_r <= shadow_nxt_s;
         end
      end
   end

   assign payload       = payload_r;
   assign payload_valid = payload_valid_r;
   assign busy          = busy_r;
   assign err           = err_r;
   assign err_code      = err_code_r;

endmodule

// File: tb/tb_pixel_packet_parser.sv
// Directed bench for pixel_packet_parser with DLEN 43, 47 and 48 instances
// sharing clock, reset, frame_start and pixel data; each has its own pixel_valid.
module tb_pixel_packet_parser;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          frame_start;
   logic [2:0]    pv;
   logic [47:0]   pixel_data;

   logic [343:0]  p43;
   logic [375:0]  p47;
   logic [383:0]  p48;
   logic [2:0]    pval, busy, err;
   logic [1:0]    code43, code47, code48;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [47:0] SOF = 48'h01000000FFEA;

   always #5 clk = ~clk;

   pixel_packet_parser #(.DLEN(32'd43)) u_dut43 (
      .rx_pixel_clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_valid(pv[0]),
      .pixel_data(pixel_data), .payload(p43), .payload_valid(pval[0]), .busy(busy[0]),
      .err(err[0]), .err_code(code43));

   pixel_packet_parser #(.DLEN(32'd47)) u_dut47 (
      .rx_pixel_clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_valid(pv[1]),
      .pixel_data(pixel_data), .payload(p47), .payload_valid(pval[1]), .busy(busy[1]),
      .err(err[1]), .err_code(code47));

   pixel_packet_parser #(.DLEN(32'd48)) u_dut48 (
      .rx_pixel_clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_valid(pv[2]),
      .pixel_data(pixel_data), .payload(p48), .payload_valid(pval[2]), .busy(busy[2]),
      .err(err[2]), .err_code(code48));

   task automatic check(input string tag, input logic [383:0] act, input logic [383:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [47:0] hdr(input int dlen, input logic [7:0] b5);
      logic [7:0] l = 8'(dlen);
      return {b5, l, 8'h00, 8'h00, 8'h00, 8'h01};
   endfunction

   // Stream: payload bytes (index ^ seed), then AA, then the given second EOF byte, then zero fill.
   function automatic logic [47:0] pay_word(input int dlen, input int k, input logic [7:0] seed,
                                            input logic [7:0] dd);
      logic [47:0] w = 48'h0;
      logic [7:0]  b;
      for (int i = 0; i < 6; i++) begin
         int idx = 6 * k + i;
         b = (idx < dlen) ? (8'(idx) ^ seed) : (idx == dlen) ? 8'hAA : (idx == dlen + 1) ? dd : 8'h00;
         w = w | (48'(b) << (8 * i));
      end
      return w;
   endfunction

   function automatic logic [383:0] exp_pay(input int dlen, input logic [7:0] seed);
      logic [383:0] r = 384'h0;
      for (int i = 0; i < dlen; i++) begin
         r = r | (384'(8'(i) ^ seed) << (8 * i));
      end
      return r;
   endfunction

   task automatic send_word(input logic [47:0] w, input int sel, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            pixel_data = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            step();
         end
      end
      pixel_data  = w;
      pv[sel]     = 1'b1;
      step();
      pv          = 3'b000;
   endtask

   task automatic send_pkt(input int sel, input int dlen, input logic [7:0] seed,
                           input logic [7:0] dd, input bit gaps);
      send_word(SOF, sel, gaps);
      send_word(hdr(dlen, 8'h00), sel, gaps);
      send_word(hdr(dlen, 8'h00), sel, gaps);
      for (int k = 0; k < (dlen + 7) / 6; k++) begin
         send_word(pay_word(dlen, k, seed, dd), sel, gaps);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      frame_start = 1'b0;
      pv          = 3'b000;
      pixel_data  = 48'h0;
      step();
      step();
      rst_n = 1'b1;
      step();

      check("rst_payload", 384'(p43), 384'h0);
      check("rst_pval", 384'(pval), 384'h0);
      check("rst_busy", 384'(busy), 384'h0);
      check("rst_err", 384'(err), 384'h0);
      check("rst_code", 384'(code43), 384'h0);

      // Test 1: good packet, payload 0x00..0x2A
      send_word(SOF, 0, 1'b0);
      check("t1_busy_sof", 384'(busy[0]), 384'h1);
      send_word(hdr(43, 8'h00), 0, 1'b0);
      send_word(hdr(43, 8'h00), 0, 1'b0);
      for (int k = 0; k < 8; k++) send_word(pay_word(43, k, 8'h00, 8'hDD), 0, 1'b0);
      check("t1_last_word", 384'(pay_word(43, 7, 8'h00, 8'hDD)), 384'(48'h000000DDAA2A));
      check("t1_pval", 384'(pval[0]), 384'h1);
      check("t1_payload", 384'(p43), exp_pay(43, 8'h00));
      check("t1_busy_end", 384'(busy[0]), 384'h0);
      check("t1_err", 384'(err[0]), 384'h0);

      // Test 2: bad header byte5, back-to-back with previous EOF
      send_word(SOF, 0, 1'b0);
      check("t2_pval_pulse", 384'(pval[0]), 384'h0);
      check("t2_busy_b2b", 384'(busy[0]), 384'h1);
      send_word(hdr(43, 8'h00), 0, 1'b0);
      send_word(hdr(43, 8'h05), 0, 1'b0);
      check("t2_err", 384'(err[0]), 384'h1);
      check("t2_code", 384'(code43), 384'h1);
      check("t2_busy", 384'(busy[0]), 384'h0);
      step();
      check("t2_err_pulse", 384'(err[0]), 384'h0);
      check("t2_code_held", 384'(code43), 384'h1);
      check("t2_payload_held", 384'(p43), exp_pay(43, 8'h00));
      send_pkt(0, 43, 8'h11, 8'hDD, 1'b0);
      check("t2_next_pval", 384'(pval[0]), 384'h1);
      check("t2_next_payload", 384'(p43), exp_pay(43, 8'h11));

      // Test 3: wrong second EOF byte
      send_pkt(0, 43, 8'h5A, 8'hAB, 1'b0);
      check("t3_err", 384'(err[0]), 384'h1);
      check("t3_code", 384'(code43), 384'h2);
      check("t3_pval", 384'(pval[0]), 384'h0);
      check("t3_payload_held", 384'(p43), exp_pay(43, 8'h11));

      // Test 4: frame_start while idle has no effect, then truncation mid-payload
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("t4_fs_idle_err", 384'(err[0]), 384'h0);
      send_word(SOF, 0, 1'b0);
      send_word(hdr(43, 8'h00), 0, 1'b0);
      send_word(hdr(43, 8'h00), 0, 1'b0);
      for (int k = 0; k < 3; k++) send_word(pay_word(43, k, 8'h22, 8'hDD), 0, 1'b0);
      frame_start = 1'b1;
      send_word(SOF, 0, 1'b0);
      frame_start = 1'b0;
      check("t4_err", 384'(err[0]), 384'h1);
      check("t4_code", 384'(code43), 384'h3);
      check("t4_busy_sof_dropped", 384'(busy[0]), 384'h0);
      send_pkt(0, 43, 8'h33, 8'hDD, 1'b0);
      check("t4_restart_pval", 384'(pval[0]), 384'h1);
      check("t4_restart_payload", 384'(p43), exp_pay(43, 8'h33));

      // Test 6a: random pixel_valid gaps give the same result as test 1
      send_pkt(0, 43, 8'h00, 8'hDD, 1'b1);
      check("t6_gaps_pval", 384'(pval[0]), 384'h1);
      check("t6_gaps_payload", 384'(p43), exp_pay(43, 8'h00));
      check("t6_gaps_err", 384'(err[0]), 384'h0);

      // Test 5: DLEN=47 EOF split across words, DLEN=48 standalone EOF word
      send_word(SOF, 1, 1'b0);
      send_word(hdr(47, 8'h00), 1, 1'b0);
      send_word(hdr(47, 8'h00), 1, 1'b0);
      for (int k = 0; k < 8; k++) send_word(pay_word(47, k, 8'h00, 8'hDD), 1, 1'b0);
      check("t5_47_no_pval_yet", 384'(pval[1]), 384'h0);
      check("t5_47_busy", 384'(busy[1]), 384'h1);
      send_word(pay_word(47, 8, 8'h00, 8'hDD), 1, 1'b0);
      check("t5_47_pval", 384'(pval[1]), 384'h1);
      check("t5_47_payload", 384'(p47), exp_pay(47, 8'h00));
      send_pkt(2, 48, 8'h00, 8'hDD, 1'b0);
      check("t5_48_eof_word", 384'(pay_word(48, 8, 8'h00, 8'hDD)), 384'(48'h00000000DDAA));
      check("t5_48_pval", 384'(pval[2]), 384'h1);
      check("t5_48_payload", 384'(p48), exp_pay(48, 8'h00));

      // Test 6b: reset mid-payload drops packet silently
      send_word(SOF, 0, 1'b0);
      send_word(hdr(43, 8'h00), 0, 1'b0);
      send_word(hdr(43, 8'h00), 0, 1'b0);
      for (int k = 0; k < 2; k++) send_word(pay_word(43, k, 8'h44, 8'hDD), 0, 1'b0);
      rst_n = 1'b0;
      #2;
      check("t6_rst_payload", 384'(p43), 384'h0);
      check("t6_rst_busy", 384'(busy[0]), 384'h0);
      check("t6_rst_err", 384'(err[0]), 384'h0);
      check("t6_rst_code", 384'(code43), 384'h0);
      step();
      rst_n = 1'b1;
      step();
      check("t6_post_rst_err", 384'(err[0]), 384'h0);
      send_pkt(0, 43, 8'h55, 8'hDD, 1'b0);
      check("t6_post_rst_pval", 384'(pval[0]), 384'h1);
      check("t6_post_rst_payload", 384'(p43), exp_pay(43, 8'h55));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
